// File: rtl/nco_pkg.sv
// nco_pkg: shared switch-debounce sizing constants and helpers
package nco_pkg;
    localparam int SW_WIDTH = 10;
    localparam int DEBOUNCE_CYCLES = 1000;  // 20 us at 50 MHz

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// debounce_bit: single-bit stability counter, debounced output register and edge pulses
module debounce_bit
    import nco_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic update
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // asserted on the edge where the output is about to take the new level
    assign update = (in != out) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= update && in;
            fall <= update && !in;
            if (in == out || update) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (update) out <= in;
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch debouncer with rise/fall pulses and a combined change pulse
module sw_debounce
    import nco_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    logic [WIDTH-1:0] update;

    if (STABLE_CYCLES < 2) begin : g_bad_cycles
        $error("sw_debounce: STABLE_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
            .clk   (clk),
            .reset (reset),
            .in    (in[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .update(update[i])
        );
    end

    // registered from the same next-state terms as rise/fall so all pulses align
    always_ff @(posedge clk) begin
        if (reset) changed <= 1'b0;
        else changed <= |update;
    end
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 10, number of independent switch bits debounced.
REQ-002 Parameter STABLE_CYCLES, default 1000, consecutive clock cycles a bit must differ from its output before the output follows.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in  input  WIDTH  switch vector, already synchronized to clk by the upstream synchronizer stage.
REQ-006 Port out  output  WIDTH  debounced switch vector, registered.
REQ-007 Port rise  output  WIDTH  per-bit one-cycle pulse, out[i] went 0->1 on the most recent edge.
REQ-008 Port fall  output  WIDTH  per-bit one-cycle pulse, out[i] went 1->0 on the most recent edge.
REQ-009 Port changed  output  1  one-cycle pulse, OR of all rise and fall bits.

Function
REQ-010 Each bit i has its own counter cnt[i], width $clog2(STABLE_CYCLES+1); bits never interact.
REQ-011 Each edge where in[i] == out[i], cnt[i] clears to 0 and out[i] holds.
REQ-012 Each edge where in[i] != out[i] and cnt[i] < STABLE_CYCLES-1, cnt[i] increments by 1 and out[i] holds.
REQ-013 Each edge where in[i] != out[i] and cnt[i] == STABLE_CYCLES-1, out[i] takes in[i] and cnt[i] clears to 0.
REQ-014 Latency: input level change sampled first at edge k and held produces the out change at edge k+STABLE_CYCLES-1; exactly STABLE_CYCLES consecutive differing samples.
REQ-015 Glitch rejection: any return of in[i] to out[i] before the final count restarts the count from 0; no partial credit.
REQ-016 rise[i]/fall[i] are registered in the same edge that updates out[i], asserted for exactly one cycle, never both set for one bit.
REQ-017 changed is registered concurrently with rise/fall, never combinational from in.
REQ-018 Simultaneous qualifying changes on several bits update all of them on the same edge, with one changed pulse.
REQ-019 Counter never wraps; saturation is impossible by REQ-013; no output depends on a count value >= STABLE_CYCLES.
REQ-020 STABLE_CYCLES < 2 is illegal; elaboration-time assertion fails.

Reset
REQ-021 While reset is high at an edge: out = 0, rise = 0, fall = 0, changed = 0, all cnt = 0.
REQ-022 Reset mid-count discards progress; after release a bit with in[i]=1 needs a full STABLE_CYCLES count to raise out[i], then pulses rise[i].
REQ-023 No rise/fall/changed pulse is generated by reset itself or on the first edge after release.

Structure
REQ-024 Shared package nco_pkg holds SW_WIDTH = 10 and DEBOUNCE_CYCLES (default 1000, e.g. 20 us at 50 MHz).
REQ-025 One sub-module debounce_bit (single-bit counter, output register, rise/fall pulse) instantiated WIDTH times by generate; the top ORs the pulses for changed.

Verification (bench uses STABLE_CYCLES = 4, WIDTH = 10, clk period 20 ns)
REQ-026 Reset with in = 10'h3FF -> out = 0 and no pulses during reset; out = 10'h3FF exactly 4 edges after release, with rise = 10'h3FF and changed = 1 for one cycle.
REQ-027 in[0] 0->1 held -> out[0] = 0 after edges 1-3, out[0] = 1 after edge 4, rise[0] high one cycle, fall = 0.
REQ-028 in[3] pulses high for 3 cycles then returns low -> out[3] stays 0, rise[3] and changed never assert.
REQ-029 in[5] high 2 cycles, low 1 cycle, high held -> out[5] rises 4 edges after the final low-to-high, not earlier.
REQ-030 out = 10'h001, then in = 10'h200 in one step -> after 4 edges out = 10'h200, rise = 10'h200, fall = 10'h001, single changed pulse.
REQ-031 reset asserted after 2 counted cycles of in[7]=1 -> out[7] = 0 throughout reset; after release out[7] = 1 only after 4 further edges.
